// File: rtl/block_hit_detect.sv
// Brick-wall hit detector: on each ball position strobe, scans the 16 blocks one per
// cycle, destroys the lowest-index overlapping live block and requests a bounce.
module block_hit_detect #(
    parameter int unsigned X0       = 62,
    parameter int unsigned Y0       = 50,
    parameter int unsigned X_PITCH  = 225,
    parameter int unsigned Y_PITCH  = 75,
    parameter int unsigned B_WIDTH  = 100,
    parameter int unsigned B_HEIGHT = 50,
    parameter int unsigned BALL     = 10
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [10:0] ball_x,
    input  logic [10:0] ball_y,
    input  logic        ball_valid,
    input  logic        restart,
    output logic [15:0] blocks_out,
    output logic        busy,
    output logic        done,
    output logic        hit,
    output logic [3:0]  hit_index,
    output logic        bounce_x,
    output logic        bounce_y,
    output logic [4:0]  score,
    output logic        all_cleared
);
    localparam int unsigned CW = 12;
    localparam int unsigned NB = 16;

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

    state_t         state_q;
    logic [3:0]     k_q;
    logic [3:0]     cand_q;
    logic           found_q;
    logic [CW-1:0]  bx_q;
    logic [CW-1:0]  by_q;

    logic [CW-1:0]  x_lo_c, x_hi_c, y_lo_c, y_hi_c;
    logic [CW-1:0]  bx_end_c, by_end_c;
    logic [CW-1:0]  cy_c, cy_lo_c, cy_hi_c;
    logic           overlap_c, cand_c, y_out_c;
    logic [NB-1:0]  blocks_upd_c;

    // Geometry of the block under test (k) and of the recorded candidate's row
    always_comb begin
        x_lo_c       = CW'(X0 + 32'(k_q[1:0]) * X_PITCH);
        x_hi_c       = x_lo_c + CW'(B_WIDTH);
        y_lo_c       = CW'(Y0 + 32'(k_q[3:2]) * Y_PITCH);
        y_hi_c       = y_lo_c + CW'(B_HEIGHT);
        bx_end_c     = bx_q + CW'(BALL - 1);
        by_end_c     = by_q + CW'(BALL - 1);
        overlap_c    = (bx_q <= x_hi_c) && (bx_end_c >= x_lo_c) &&
                       (by_q <= y_hi_c) && (by_end_c >= y_lo_c);
        cand_c       = overlap_c && !blocks_out[k_q];
        cy_c         = by_q + CW'(BALL / 2);
        cy_lo_c      = CW'(Y0 + 32'(cand_q[3:2]) * Y_PITCH);
        cy_hi_c      = cy_lo_c + CW'(B_HEIGHT);
        y_out_c      = (cy_c < cy_lo_c) || (cy_c > cy_hi_c);
        blocks_upd_c = blocks_out | NB'(16'd1 << cand_q);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= 4'd0;
            cand_q      <= 4'd0;
            found_q     <= 1'b0;
            bx_q        <= '0;
            by_q        <= '0;
            blocks_out  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit         <= 1'b0;
            hit_index   <= 4'd0;
            bounce_x    <= 1'b0;
            bounce_y    <= 1'b0;
            score       <= 5'd0;
            all_cleared <= 1'b0;
        end else begin
            done     <= 1'b0;
            hit      <= 1'b0;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            if (restart) begin
                state_q     <= IDLE;
                k_q         <= 4'd0;
                busy        <= 1'b0;
                blocks_out  <= '0;
                score       <= 5'd0;
                all_cleared <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ball_valid) begin
                            bx_q    <= CW'(ball_x);
                            by_q    <= CW'(ball_y);
                            k_q     <= 4'd0;
                            found_q <= 1'b0;
                            busy    <= 1'b1;
                            state_q <= SCAN;
                        end
                    end
                    SCAN: begin
                        // Only the first (lowest-index) candidate is kept
                        if (cand_c && !found_q) begin
                            found_q <= 1'b1;
                            cand_q  <= k_q;
                        end
                        if (k_q == 4'd15) begin
                            state_q <= UPDATE;
                        end else begin
                            k_q <= k_q + 4'd1;
                        end
                    end
                    UPDATE: begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                        if (found_q) begin
                            blocks_out  <= blocks_upd_c;
                            score       <= score + 5'd1;
                            hit_index   <= cand_q;
                            hit         <= 1'b1;
                            bounce_y    <= y_out_c;
                            bounce_x    <= !y_out_c;
                            all_cleared <= (blocks_upd_c == '1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_block_hit_detect.sv
// Randomized and directed bench for block_hit_detect against a geometric model of the wall.
module tb_block_hit_detect;
    logic        pclk = 1'b0;
    logic        reset;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic        ball_valid;
    logic        restart;
    logic [15:0] blocks_out;
    logic        busy;
    logic        done;
    logic        hit;
    logic [3:0]  hit_index;
    logic        bounce_x;
    logic        bounce_y;
    logic [4:0]  score;
    logic        all_cleared;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    bit destroyed [16];
    int m_score;
    int m_index;

    block_hit_detect dut (
        .pclk        (pclk),
        .reset       (reset),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .ball_valid  (ball_valid),
        .restart     (restart),
        .blocks_out  (blocks_out),
        .busy        (busy),
        .done        (done),
        .hit         (hit),
        .hit_index   (hit_index),
        .bounce_x    (bounce_x),
        .bounce_y    (bounce_y),
        .score       (score),
        .all_cleared (all_cleared)
    );

    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int blk_x(input int i);
        return 62 + (i % 4) * 225;
    endfunction

    function automatic int blk_y(input int i);
        return 50 + (i / 4) * 75;
    endfunction

    function automatic int model_cand(input int bx, input int by);
        for (int i = 0; i < 16; i++) begin
            if (!destroyed[i] &&
                bx <= blk_x(i) + 100 && bx + 9 >= blk_x(i) &&
                by <= blk_y(i) + 50  && by + 9 >= blk_y(i))
                return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[i] = destroyed[i];
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) destroyed[i] = 1'b0;
        m_score = 0;
    endtask

    // Runs one full scan; optionally re-strobes ball_valid mid-scan with other coordinates
    task automatic run_frame(input int bx, input int by, input bit repulse);
        int c;
        bit eby;
        c = model_cand(bx, by);
        ball_x = 11'(bx);
        ball_y = 11'(by);
        ball_valid = 1'b1;
        @(posedge pclk); #1;
        ball_valid = 1'b0;
        check_val("busy_start", 32'(busy), 32'd1);
        for (int j = 1; j <= 16; j++) begin
            if (repulse && j == 5) begin
                ball_x = 11'((bx + 300) % 2048);
                ball_y = 11'((by + 200) % 2048);
                ball_valid = 1'b1;
            end
            if (j == 6) ball_valid = 1'b0;
            @(posedge pclk); #1;
            check_val("busy_scan", 32'(busy), 32'd1);
            check_val("done_early", 32'(done), 32'd0);
        end
        ball_valid = 1'b0;
        @(posedge pclk); #1;
        eby = 1'b0;
        if (c >= 0) begin
            destroyed[c] = 1'b1;
            m_score++;
            m_index = c;
            eby = ((by + 5) < blk_y(c)) || ((by + 5) > blk_y(c) + 50);
        end
        check_val("done", 32'(done), 32'd1);
        check_val("busy_end", 32'(busy), 32'd0);
        check_val("hit", 32'(hit), (c >= 0) ? 32'd1 : 32'd0);
        check_val("hit_index", 32'(hit_index), 32'(m_index));
        check_val("bounce_y", 32'(bounce_y), (c >= 0 && eby) ? 32'd1 : 32'd0);
        check_val("bounce_x", 32'(bounce_x), (c >= 0 && !eby) ? 32'd1 : 32'd0);
        check_val("blocks_out", 32'(blocks_out), 32'(model_mask()));
        check_val("score", 32'(score), 32'(m_score));
        check_val("all_cleared", 32'(all_cleared), (m_score == 16) ? 32'd1 : 32'd0);
        @(posedge pclk); #1;
        check_val("done_pulse", 32'(done), 32'd0);
        check_val("hit_pulse", 32'(hit), 32'd0);
        if (repulse) begin
            for (int j = 0; j < 20; j++) begin
                @(posedge pclk); #1;
                check_val("done_extra", 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        int bx, by;
        reset = 1'b1;
        restart = 1'b0;
        ball_valid = 1'b0;
        ball_x = '0;
        ball_y = '0;
        model_clear();
        m_index = 0;
        repeat (3) @(posedge pclk);
        #1;
        check_val("rst_blocks", 32'(blocks_out), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_score", 32'(score), 32'd0);
        check_val("rst_index", 32'(hit_index), 32'd0);
        check_val("rst_clear", 32'(all_cleared), 32'd0);
        reset = 1'b0;
        @(posedge pclk); #1;

        // Directed positions, including inclusive-edge contacts
        run_frame(0, 400, 1'b0);
        run_frame(100, 96, 1'b0);
        run_frame(100, 96, 1'b0);
        run_frame(282, 140, 1'b0);
        run_frame(388, 60, 1'b0);
        run_frame(387, 60, 1'b0);
        run_frame(503, 60, 1'b0);
        run_frame(740, 41, 1'b0);
        run_frame(2047, 2047, 1'b0);
        run_frame(62 + 3 * 225 + 40, 50 + 3 * 75 + 20, 1'b1);

        // Random frames
        for (int n = 0; n < 40; n++) begin
            if (n % 8 == 7) begin
                bx = $urandom_range(2047, 2030);
                by = $urandom_range(2047, 0);
            end else begin
                bx = $urandom_range(900, 0);
                by = $urandom_range(400, 0);
            end
            run_frame(bx, by, 1'b0);
        end

        // Clear the remaining wall, then scan once more with nothing left
        for (int i = 0; i < 16; i++) begin
            if (!destroyed[i]) run_frame(blk_x(i) + 40, blk_y(i) + 20, 1'b0);
        end
        check_val("score_full", 32'(score), 32'd16);
        check_val("all_cleared_set", 32'(all_cleared), 32'd1);
        run_frame(blk_x(5) + 40, blk_y(5) + 20, 1'b0);

        restart = 1'b1;
        @(posedge pclk); #1;
        restart = 1'b0;
        model_clear();
        check_val("rs_blocks", 32'(blocks_out), 32'd0);
        check_val("rs_score", 32'(score), 32'd0);
        check_val("rs_clear", 32'(all_cleared), 32'd0);
        check_val("rs_busy", 32'(busy), 32'd0);
        check_val("rs_done", 32'(done), 32'd0);
        run_frame(blk_x(0) + 40, blk_y(0) + 20, 1'b0);

        // Reset in the middle of a scan that would hit
        ball_x = 11'(blk_x(6) + 40);
        ball_y = 11'(blk_y(6) + 20);
        ball_valid = 1'b1;
        @(posedge pclk); #1;
        ball_valid = 1'b0;
        repeat (7) @(posedge pclk);
        #1;
        reset = 1'b1;
        @(posedge pclk); #1;
        reset = 1'b0;
        model_clear();
        m_index = 0;
        check_val("mr_blocks", 32'(blocks_out), 32'd0);
        check_val("mr_busy", 32'(busy), 32'd0);
        check_val("mr_index", 32'(hit_index), 32'd0);
        for (int j = 0; j < 20; j++) begin
            @(posedge pclk); #1;
            check_val("mr_done", 32'(done), 32'd0);
            check_val("mr_hit", 32'(hit), 32'd0);
        end
        check_val("mr_blocks_end", 32'(blocks_out), 32'd0);
        run_frame(blk_x(6) + 40, blk_y(6) + 20, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
